regfile_bypass_sb: RTL and testbench
====================================

REGFILE_BYPASS_SB -- requirements
Module: regfile_bypass_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1, where 1 hardwires register 0 to zero.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports rd0_addr, rd1_addr, input, ADDR_W, read-port addresses.
REQ-007 SHALL have ports rd0_data, rd1_data, output, DATA_W, read data, combinational.
REQ-008 SHALL have ports rd0_busy, rd1_busy, output, 1, addressed register has a pending producer.
REQ-009 SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_W) and wr_data (input, DATA_W), the writeback port.
REQ-010 SHALL have ports iss_en (input, 1) and iss_addr (input, ADDR_W), which mark a destination register pending.
REQ-011 SHALL have port flush, input, 1, which clears all pending marks.
REQ-012 SHALL have port busy_cnt, output, ADDR_W+1, registered count of pending registers.

Function
REQ-013 SHALL write wr_data to mem[wr_addr] on the rising clk edge when wr_en=1.
REQ-014 When ZERO_REG=1, SHALL ignore writes and issues to address 0, and reads of address 0 SHALL return 0 with busy=0.
REQ-015 SHALL bypass writes: if wr_en=1 and wr_addr==rdN_addr (excluding the zero-register case), rdN_data SHALL equal wr_data in the same cycle.
REQ-016 Otherwise, rdN_data SHALL equal mem[rdN_addr]; there is zero read latency.
REQ-017 SHALL set busy[iss_addr] on the clock edge when iss_en=1.
REQ-018 SHALL clear busy[wr_addr] on the clock edge when wr_en=1.
REQ-019 When iss_en and wr_en target the same address in the same cycle, the data SHALL be written and busy SHALL end at 1 (new producer wins).
REQ-020 rdN_busy SHALL equal busy[rdN_addr] AND NOT (wr_en AND wr_addr==rdN_addr), so the bypass resolves the hazard in the same cycle.
REQ-021 Issue to an already-busy register SHALL leave busy=1 and busy_cnt unchanged.
REQ-022 Writeback to a non-busy register SHALL update data and leave busy_cnt unchanged.
REQ-023 busy_cnt SHALL track popcount(busy) exactly each cycle:
  - +1 when a clear register is newly set;
  - -1 when a busy register is cleared and not re-set;
  - net 0 when both events occur.
REQ-024 flush=1 SHALL clear all busy bits and set busy_cnt=0 on the next edge, and flush SHALL override a same-cycle iss_en.
REQ-025 A same-cycle wr_en SHALL still update data during flush.
REQ-026 busy_cnt SHALL never wrap: its maximum is 2**ADDR_W-ZERO_REG, and it SHALL never go below 0.

Reset
REQ-027 On rst_n=0, SHALL asynchronously clear all mem entries to 0, all busy bits to 0, and busy_cnt to 0.
REQ-028 During reset, rd*_data SHALL read 0 (bypass excepted) and rd*_busy SHALL read 0.
REQ-029 SHALL ignore wr_en and iss_en while rst_n=0.
REQ-030 Reset release SHALL be followed by normal operation from the first rising edge.

Structure
REQ-031 Shared package regfile_pkg SHALL hold the default DATA_W, ADDR_W and ZERO_REG constants and a function for the busy_cnt width.
REQ-032 A sub-module rf_read_port (address compare, bypass mux, zero-register mask, busy gating) SHALL be instantiated once per read port.
REQ-033 Storage, busy vector, counter and flush logic SHALL reside in the top module.

Verification
REQ-034 The bench SHALL cover:
  - Write-bypass case: apply reset, then wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rd0_addr=5 in the same cycle -> rd0_data=0xDEADBEEF combinationally, and it still reads 0xDEADBEEF after the edge.
  - Zero-register case: with ZERO_REG=1, apply wr_en at address 0 with 0xFFFFFFFF and iss_en at address 0 -> rd1_addr=0 gives data 0, busy 0, busy_cnt 0.
  - Issue then writeback case: iss at address 3 -> rd0_busy=1, busy_cnt=1; later wr at address 3 with 0x12 -> rd0_busy=0 in that cycle, busy_cnt=0 after the edge.
  - Simultaneous iss and wr at address 7 while address 7 is busy -> data updated, busy stays 1, busy_cnt unchanged.
  - Issue to addresses 1..31, then flush with iss_en at address 2 -> busy_cnt 31 then 0, and all busy flags 0.
  - Reset mid-operation: assert rst_n=0 asynchronously between edges with busy_cnt=4 -> immediate zero on data, busy and busy_cnt.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file with write bypass.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32'sd32;
    localparam int DEF_ADDR_W   = 32'sd5;
    localparam bit DEF_ZERO_REG = 1'b1;

    // Counter must hold the full depth, so it is one bit wider than the address.
    function automatic int cnt_width(input int addr_w);
        return addr_w + 32'sd1;
    endfunction

endpackage

// File: rtl/regfile_bypass_sb_rd.sv
// One read port: zero-register mask, same-cycle writeback bypass and busy gating.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = DEF_ZERO_REG
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              busy_bit,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic is_zero_s;
    logic hit_s;

    assign is_zero_s = ZERO_REG && (rd_addr == {ADDR_W{1'b0}});
    assign hit_s     = wr_en && (wr_addr == rd_addr);

    // A writeback to the addressed register supplies the data and resolves the hazard now.
    always_comb begin
        rd_data = mem_data;
        rd_busy = busy_bit;
        if (is_zero_s) begin
            rd_data = {DATA_W{1'b0}};
            rd_busy = 1'b0;
        end else if (hit_s) begin
            rd_data = wr_data;
            rd_busy = 1'b0;
        end else begin
            rd_data = mem_data;
            rd_busy = busy_bit;
        end
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Register file with two bypassed read ports and a per-register pending (scoreboard) bit.
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = DEF_ZERO_REG
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_W-1:0]              rd0_addr,
    input  logic [ADDR_W-1:0]              rd1_addr,
    output logic [DATA_W-1:0]              rd0_data,
    output logic [DATA_W-1:0]              rd1_data,
    output logic                           rd0_busy,
    output logic                           rd1_busy,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           iss_en,
    input  logic [ADDR_W-1:0]              iss_addr,
    input  logic                           flush,
    output logic [cnt_width(ADDR_W)-1:0]   busy_cnt
);

    localparam int DEPTH = 32'sd1 << ADDR_W;
    localparam int CW    = cnt_width(ADDR_W);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_nxt_s;
    logic              wr_ok_s;
    logic              iss_ok_s;
    logic              set_new_s;
    logic              clr_done_s;

    assign wr_ok_s  = wr_en  && !(ZERO_REG && (wr_addr  == {ADDR_W{1'b0}}));
    assign iss_ok_s = iss_en && !(ZERO_REG && (iss_addr == {ADDR_W{1'b0}}));

    // A clear that is re-set by a same-address issue is not a net clear.
    assign set_new_s  = iss_ok_s && !busy_r[iss_addr];
    assign clr_done_s = wr_ok_s && busy_r[wr_addr] && !(iss_ok_s && (iss_addr == wr_addr));

    // Next busy vector and count; flush drops every pending mark and beats any issue.
    always_comb begin
        busy_nxt_s = busy_r;
        cnt_nxt_s  = cnt_r;
        if (flush) begin
            busy_nxt_s = {DEPTH{1'b0}};
            cnt_nxt_s  = {CW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                busy_nxt_s[wr_addr] = 1'b0;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
            if (iss_ok_s) begin
                busy_nxt_s[iss_addr] = 1'b1;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
            cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, set_new_s} - {{(CW-1){1'b0}}, clr_done_s};
        end
    end

    // Storage; writes proceed during flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end else begin
            mem_r[wr_addr] <= mem_r[wr_addr];
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {DEPTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign busy_cnt = cnt_r;

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd0 (
        .rd_addr  (rd0_addr),
        .mem_data (mem_r[rd0_addr]),
        .busy_bit (busy_r[rd0_addr]),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rd0_data),
        .rd_busy  (rd0_busy)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd1 (
        .rd_addr  (rd1_addr),
        .mem_data (mem_r[rd1_addr]),
        .busy_bit (busy_r[rd1_addr]),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rd1_data),
        .rd_busy  (rd1_busy)
    );

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed vector table plus hand-written sequences for flush, saturation and async reset.
module tb_regfile_bypass_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd0_addr, rd1_addr;
    logic [31:0] rd0_data, rd1_data;
    logic        rd0_busy, rd1_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [5:0]  busy_cnt;

    int errors = 0;
    int checks = 0;

    regfile_bypass_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd0_addr (rd0_addr),
        .rd1_addr (rd1_addr),
        .rd0_data (rd0_data),
        .rd1_data (rd1_data),
        .rd0_busy (rd0_busy),
        .rd1_busy (rd1_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic        flush;
        logic [4:0]  rd0_addr;
        logic [4:0]  rd1_addr;
        logic [31:0] e_rd0_data;
        logic        e_rd0_busy;
        logic [31:0] e_rd1_data;
        logic        e_rd1_busy;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia, input logic fl,
                         input logic [4:0] r0, input logic [4:0] r1);
        wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia; flush = fl;
        rd0_addr = r0; rd1_addr = r1;
    endtask

    initial begin
        // wr  waddr  wdata  iss iaddr fl  rd0 rd1 | rd0_data busy0 rd1_data busy1 cnt
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 6'd0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 6'd0};
        vecs[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0, 5'd3, 5'd5, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 6'd0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 32'h0, 1'b1, 32'h0, 1'b1, 6'd1};
        vecs[6]  = '{1'b1, 5'd3, 32'h12,       1'b0, 5'd0, 1'b0, 5'd3, 5'd5, 32'h12, 1'b0, 32'hDEADBEEF, 1'b0, 6'd1};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 32'h12, 1'b0, 32'h12, 1'b0, 6'd0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd3, 32'h0, 1'b0, 32'h12, 1'b0, 6'd0};
        vecs[9]  = '{1'b1, 5'd7, 32'hA5A5,     1'b1, 5'd7, 1'b0, 5'd7, 5'd7, 32'hA5A5, 1'b0, 32'hA5A5, 1'b0, 6'd1};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 32'hA5A5, 1'b1, 32'h0, 1'b0, 6'd1};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd7, 32'hA5A5, 1'b1, 32'hA5A5, 1'b1, 6'd1};
        vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 32'hA5A5, 1'b1, 32'h0, 1'b0, 6'd1};
        vecs[13] = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 1'b0, 5'd9, 5'd7, 32'h99, 1'b0, 32'hA5A5, 1'b1, 6'd1};
        vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd7, 32'h99, 1'b0, 32'hA5A5, 1'b1, 6'd1};
        vecs[15] = '{1'b1, 5'd7, 32'h77,       1'b1, 5'd4, 1'b0, 5'd7, 5'd4, 32'h77, 1'b0, 32'h0, 1'b0, 6'd1};
        vecs[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd4, 32'h77, 1'b0, 32'h0, 1'b1, 6'd1};
        vecs[17] = '{1'b1, 5'd4, 32'h44,       1'b1, 5'd6, 1'b1, 5'd4, 5'd6, 32'h44, 1'b0, 32'h0, 1'b0, 6'd1};
        vecs[18] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd4, 5'd6, 32'h44, 1'b0, 32'h0, 1'b0, 6'd0};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
        #12;
        chk("reset_cnt", {26'd0, busy_cnt}, 32'd0);
        chk("reset_rd0_data", rd0_data, 32'h0);
        chk("reset_rd0_busy", {31'd0, rd0_busy}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data, vecs[i].iss_en,
                  vecs[i].iss_addr, vecs[i].flush, vecs[i].rd0_addr, vecs[i].rd1_addr);
            #2;
            chk($sformatf("v%0d_rd0_data", i), rd0_data, vecs[i].e_rd0_data);
            chk($sformatf("v%0d_rd0_busy", i), {31'd0, rd0_busy}, {31'd0, vecs[i].e_rd0_busy});
            chk($sformatf("v%0d_rd1_data", i), rd1_data, vecs[i].e_rd1_data);
            chk($sformatf("v%0d_rd1_busy", i), {31'd0, rd1_busy}, {31'd0, vecs[i].e_rd1_busy});
            chk($sformatf("v%0d_cnt", i), {26'd0, busy_cnt}, {26'd0, vecs[i].e_cnt});
        end

        // Issue to every address (0 is ignored) then once more to 0: count saturates at 31.
        for (int a = 0; a < 33; a++) begin
            @(posedge clk); #1;
            drive(1'b0, 5'd0, 32'h0, 1'b1, (a == 32) ? 5'd0 : 5'(a), 1'b0, 5'd0, 5'd0);
        end
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        #2;
        chk("all_issued_cnt", {26'd0, busy_cnt}, 32'd31);
        for (int a = 1; a < 32; a += 2) begin
            rd0_addr = 5'(a);
            rd1_addr = 5'(a + 1);
            #1;
            chk($sformatf("all_busy_%0d", a), {31'd0, rd0_busy}, 32'd1);
            chk($sformatf("all_busy_%0d", a + 1), {31'd0, rd1_busy}, (a == 31) ? 32'd0 : 32'd1);
        end

        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b1, 5'd2, 5'd0);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        #1;
        chk("flush_cnt", {26'd0, busy_cnt}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rd0_addr = 5'(a);
            #1;
            chk($sformatf("flushed_busy_%0d", a), {31'd0, rd0_busy}, 32'd0);
        end

        // Build up four pending registers, then pull reset between edges.
        @(posedge clk); #1; drive(1'b1, 5'd10, 32'hAB, 1'b1, 5'd10, 1'b0, 5'd10, 5'd3);
        @(posedge clk); #1; drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 1'b0, 5'd10, 5'd3);
        @(posedge clk); #1; drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, 5'd10, 5'd3);
        @(posedge clk); #1; drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 1'b0, 5'd10, 5'd3);
        @(posedge clk); #1; drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd3);
        #1;
        chk("pre_reset_cnt", {26'd0, busy_cnt}, 32'd4);
        chk("pre_reset_rd0_data", rd0_data, 32'hAB);
        chk("pre_reset_rd0_busy", {31'd0, rd0_busy}, 32'd1);
        chk("pre_reset_rd1_data", rd1_data, 32'h12);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_cnt", {26'd0, busy_cnt}, 32'd0);
        chk("async_reset_rd0_data", rd0_data, 32'h0);
        chk("async_reset_rd0_busy", {31'd0, rd0_busy}, 32'd0);
        chk("async_reset_rd1_data", rd1_data, 32'h0);

        // Writes and issues while reset is held are ignored.
        drive(1'b1, 5'd20, 32'hBAD, 1'b1, 5'd20, 1'b0, 5'd0, 5'd20);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd20);
        #1;
        chk("in_reset_write_ignored", rd1_data, 32'h0);
        chk("in_reset_issue_ignored", {26'd0, busy_cnt}, 32'd0);
        rst_n = 1'b1;

        @(posedge clk); #1; drive(1'b1, 5'd15, 32'h15, 1'b1, 5'd16, 1'b0, 5'd15, 5'd16);
        @(posedge clk); #1; drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd15, 5'd16);
        #1;
        chk("post_reset_data", rd0_data, 32'h15);
        chk("post_reset_busy", {31'd0, rd1_busy}, 32'd1);
        chk("post_reset_cnt", {26'd0, busy_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
